// File: rtl/spi_pkg.sv
// Shared definitions for the single-byte SPI master used on the SD-card path.
// Holds the frame FSM state encoding, the frame geometry and the idle level
// of the MOSI line. No ports; imported by spi_clk_gen and spi_master.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  localparam int         FRAME_BITS = 8;
  // Half-periods spent in SHIFT: one leading and one trailing half per bit.
  localparam int         SHIFT_HALVES = 2 * FRAME_BITS;
  localparam logic [3:0] LAST_HALF = 4'(SHIFT_HALVES - 1);
  // SD cards treat a high MOSI as "no command", so the line rests at 1.
  localparam logic       MOSI_IDLE = 1'b1;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timebase for spi_master.
// A frame is built from half-periods of H = div+1 clk cycles. This block
// counts clk cycles inside the current half and flags its last cycle (tick),
// and counts the half-periods spent in the SHIFT phase (edge_idx 0..15).
// Ports:
//   clk, rst   system clock, asynchronous active-high reset
//   start      frame accepted this cycle: latch div, restart both counters
//   run        frame in progress (FSM not idle)
//   shift_en   FSM is in the SHIFT phase; edge_idx advances on each tick
//   div        half-period divider D, sampled only on start
//   tick       last clk cycle of the current half-period
//   edge_idx   index of the current SHIFT half-period
module spi_clk_gen
  import spi_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic       shift_en,
  input  logic [7:0] div,
  output logic       tick,
  output logic [3:0] edge_idx
);

  logic [7:0] div_q;
  logic [7:0] cnt_q;

  // Divider is frozen for the whole frame so mid-frame changes cannot
  // stretch or shorten a half-period.
  always_ff @(posedge clk) begin
    if (start) begin
      div_q <= div;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      edge_idx <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      edge_idx <= '0;
    end else if (run) begin
      if (tick) begin
        cnt_q <= '0;
        if (shift_en) begin
          edge_idx <= edge_idx + 4'd1;
        end
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign tick = run && (cnt_q == div_q);

endmodule

// File: rtl/spi_master.sv
// Single-byte SPI master for the SD-card driver path.
// One request shifts one 8-bit frame MSB first: write_en transmits
// data_write, read_en receives into data_read with MOSI held high, both
// together run one full-duplex frame. Requests are only taken while idle.
// A frame is SETUP (1 half), SHIFT (16 halves), HOLD (1 half), GAP (1 half),
// so the busy flags stay high for exactly 19*H clk cycles.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   spi_clk_div  half-period divider D (H = D+1), latched at frame start
//   data_write   byte to send, latched when the request is accepted
//   write_en     one-cycle transmit request
//   read_en      one-cycle receive request
//   spi_miso     serial data from the card
//   data_read    last received byte, updated at the end of a read frame
//   spi_clk      serial clock, CPOL when idle
//   spi_cs       active-low chip select
//   write_busy   write frame in progress
//   read_busy    read frame in progress
//   spi_mosi     serial data to the card, high when idle
// Every output is a flop; no input reaches an output combinationally.
module spi_master
  import spi_pkg::*;
#(
  parameter bit CPOL = 1'b1,
  parameter bit CPAH = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] spi_clk_div,
  input  logic [7:0] data_write,
  input  logic       write_en,
  input  logic       read_en,
  input  logic       spi_miso,
  output logic [7:0] data_read,
  output logic       spi_clk,
  output logic       spi_cs,
  output logic       write_busy,
  output logic       read_busy,
  output logic       spi_mosi
);

  spi_state_t state_q;
  spi_state_t state_d;

  logic       accept;
  logic       tick;
  logic [3:0] edge_idx;

  logic       edge_evt;
  logic [3:0] edge_num;
  logic       leading;
  logic       shift_evt;
  logic       sample_evt;

  logic [7:0] tx_word;
  logic [7:0] tx_q;
  logic [7:0] rx_q;

  assign accept = (state_q == IDLE) && (write_en || read_en);

  spi_clk_gen u_clk_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (accept),
    .run      (state_q != IDLE),
    .shift_en (state_q == SHIFT),
    .div      (spi_clk_div),
    .tick     (tick),
    .edge_idx (edge_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   if (tick) state_d = SHIFT;
      SHIFT:   if (tick && (edge_idx == LAST_HALF)) state_d = HOLD;
      HOLD:    if (tick) state_d = GAP;
      GAP:     if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Serial clock edges: edge 0 opens the first SHIFT half, edges 1..15 open
  // the following halves. Sixteen toggles leave spi_clk at CPOL for the last
  // SHIFT half and HOLD. Even edges are leading, odd edges trailing.
  always_comb begin
    edge_evt   = 1'b0;
    edge_num   = '0;
    shift_evt  = 1'b0;
    sample_evt = 1'b0;
    if (tick && (state_q == SETUP)) begin
      edge_evt = 1'b1;
      edge_num = '0;
    end else if (tick && (state_q == SHIFT) && (edge_idx != LAST_HALF)) begin
      edge_evt = 1'b1;
      edge_num = edge_idx + 4'd1;
    end
    leading = ~edge_num[0];
    if (edge_evt) begin
      if (CPAH) begin
        shift_evt  = leading;
        sample_evt = ~leading;
      end else begin
        // bit7 went out in SETUP, so only 7 trailing edges shift.
        shift_evt  = ~leading && (edge_num != LAST_HALF);
        sample_evt = leading;
      end
    end
  end

  // Read-only frames load all ones so MOSI stays at the idle level. With
  // CPAH=0 bit7 leaves at accept, so the register starts at bit6.
  always_comb begin
    tx_word = write_en ? data_write : 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      tx_q <= CPAH ? tx_word : {tx_word[6:0], MOSI_IDLE};
    end else if (shift_evt) begin
      tx_q <= {tx_q[6:0], MOSI_IDLE};
    end
    if (sample_evt) begin
      rx_q <= {rx_q[6:0], spi_miso};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_clk    <= CPOL;
      spi_cs     <= 1'b1;
      spi_mosi   <= MOSI_IDLE;
      write_busy <= 1'b0;
      read_busy  <= 1'b0;
      data_read  <= 8'h00;
    end else begin
      // IDLE -> SETUP
      if (accept) begin
        spi_cs     <= 1'b0;
        write_busy <= write_en;
        read_busy  <= read_en;
        spi_mosi   <= CPAH ? MOSI_IDLE : tx_word[7];
      end
      // SETUP/SHIFT half boundaries
      if (edge_evt) begin
        spi_clk <= ~spi_clk;
      end
      if (shift_evt) begin
        spi_mosi <= tx_q[7];
      end
      // SHIFT -> HOLD
      if ((state_q == SHIFT) && (state_d == HOLD) && read_busy) begin
        data_read <= rx_q;
      end
      // HOLD -> GAP
      if ((state_q == HOLD) && tick) begin
        spi_cs   <= 1'b1;
        spi_mosi <= MOSI_IDLE;
      end
      // GAP -> IDLE
      if ((state_q == GAP) && tick) begin
        write_busy <= 1'b0;
        read_busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances share the request inputs, one built
// CPOL=1/CPAH=1 (index 0) and one CPOL=0/CPAH=0 (index 1). Each has its own
// SPI slave model that captures MOSI on its sampling edges and serves a byte
// on MISO, plus counters for busy, chip-select and clock-edge timing.
module tb_spi_master;

  localparam logic [1:0] POL = 2'b01;
  localparam logic [1:0] PHA = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] spi_clk_div = '0;
  logic [7:0] data_write = '0;
  logic       write_en = 1'b0;
  logic       read_en = 1'b0;

  logic [1:0]      miso = 2'b11;
  logic [1:0][7:0] dr;
  logic [1:0]      sclk, cs, mosi, wb, rb;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_master #(.CPOL(1'b1), .CPAH(1'b1)) dut_11 (
    .clk(clk), .rst(rst), .spi_clk_div(spi_clk_div), .data_write(data_write),
    .write_en(write_en), .read_en(read_en), .spi_miso(miso[0]),
    .data_read(dr[0]), .spi_clk(sclk[0]), .spi_cs(cs[0]),
    .write_busy(wb[0]), .read_busy(rb[0]), .spi_mosi(mosi[0])
  );

  spi_master #(.CPOL(1'b0), .CPAH(1'b0)) dut_00 (
    .clk(clk), .rst(rst), .spi_clk_div(spi_clk_div), .data_write(data_write),
    .write_en(write_en), .read_en(read_en), .spi_miso(miso[1]),
    .data_read(dr[1]), .spi_clk(sclk[1]), .spi_cs(cs[1]),
    .write_busy(wb[1]), .read_busy(rb[1]), .spi_mosi(mosi[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave model and frame statistics, sampled on the falling clk edge.
  int         cyc = 0;
  logic [1:0] p_sclk = 2'b01;
  logic [1:0] p_cs = 2'b11;
  int         edges[2], last_e[2], min_sp[2], max_sp[2];
  int         cs_low[2], wb_n[2], rb_n[2], frames[2], idle_bad[2];
  logic [7:0] mosi_got[2], slv_sh[2];
  logic [7:0] slave_byte = 8'hFF;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      p_sclk[i] <= sclk[i];
      p_cs[i]   <= cs[i];
      if (cs[i] && ((sclk[i] !== POL[i]) || (mosi[i] !== 1'b1)))
        idle_bad[i] <= idle_bad[i] + 1;
      if (p_cs[i] && !cs[i]) begin
        frames[i]   <= frames[i] + 1;
        edges[i]    <= 0;
        cs_low[i]   <= 1;
        wb_n[i]     <= wb[i] ? 1 : 0;
        rb_n[i]     <= rb[i] ? 1 : 0;
        mosi_got[i] <= 8'h00;
        min_sp[i]   <= 1000000;
        max_sp[i]   <= 0;
        if (!PHA[i]) begin
          miso[i]   <= slave_byte[7];
          slv_sh[i] <= {slave_byte[6:0], 1'b1};
        end else begin
          slv_sh[i] <= slave_byte;
        end
      end else begin
        if (!cs[i]) cs_low[i] <= cs_low[i] + 1;
        if (wb[i]) wb_n[i] <= wb_n[i] + 1;
        if (rb[i]) rb_n[i] <= rb_n[i] + 1;
        if (sclk[i] != p_sclk[i]) begin
          edges[i]  <= edges[i] + 1;
          last_e[i] <= cyc;
          if (edges[i] > 0) begin
            if (cyc - last_e[i] < min_sp[i]) min_sp[i] <= cyc - last_e[i];
            if (cyc - last_e[i] > max_sp[i]) max_sp[i] <= cyc - last_e[i];
          end
          // Slave shifts MISO on the edge where the master shifts MOSI and
          // captures MOSI on the other one.
          if ((sclk[i] != POL[i]) == PHA[i]) begin
            miso[i]   <= slv_sh[i][7];
            slv_sh[i] <= {slv_sh[i][6:0], 1'b1};
          end else begin
            mosi_got[i] <= {mosi_got[i][6:0], mosi[i]};
          end
        end
      end
    end
  end

  logic [7:0] exp_dr = 8'h00;

  task automatic run_frame(input bit wr, input bit rd, input logic [7:0] tx,
                           input logic [7:0] sb, input logic [7:0] d, input bit poke);
    int f0[2];
    int h;
    int guard;
    int limit;
    h = int'(d) + 1;
    limit = 19 * 256 + 16;
    @(negedge clk);
    f0[0] = frames[0];
    f0[1] = frames[1];
    slave_byte  = sb;
    spi_clk_div = d;
    data_write  = tx;
    write_en    = wr;
    read_en     = rd;
    @(negedge clk);
    write_en    = 1'b0;
    read_en     = 1'b0;
    spi_clk_div = 8'($urandom);
    data_write  = 8'($urandom);
    check_eq("wbusy_rise", 32'(wb), 32'({wr, wr}));
    check_eq("rbusy_rise", 32'(rb), 32'({rd, rd}));
    if (poke) begin
      repeat (3) @(negedge clk);
      write_en = 1'b1;
      read_en  = 1'b1;
      @(negedge clk);
      write_en = 1'b0;
      read_en  = 1'b0;
    end
    guard = 0;
    while (((wb != 2'b00) || (rb != 2'b00)) && (guard < limit)) begin
      @(negedge clk);
      guard++;
    end
    check_eq("frame_done", 32'(guard < limit), 32'd1);
    repeat (3) @(negedge clk);
    if (rd) exp_dr = sb;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("frames[%0d]", i), 32'(frames[i] - f0[i]), 32'd1);
      check_eq($sformatf("wbusy_len[%0d]", i), 32'(wb_n[i]), wr ? 32'(19 * h) : 32'd0);
      check_eq($sformatf("rbusy_len[%0d]", i), 32'(rb_n[i]), rd ? 32'(19 * h) : 32'd0);
      check_eq($sformatf("cs_low_len[%0d]", i), 32'(cs_low[i]), 32'(18 * h));
      check_eq($sformatf("sclk_edges[%0d]", i), 32'(edges[i]), 32'd16);
      check_eq($sformatf("sclk_min_half[%0d]", i), 32'(min_sp[i]), 32'(h));
      check_eq($sformatf("sclk_max_half[%0d]", i), 32'(max_sp[i]), 32'(h));
      check_eq($sformatf("mosi_byte[%0d]", i), 32'(mosi_got[i]), wr ? 32'(tx) : 32'hFF);
      check_eq($sformatf("data_read[%0d]", i), 32'(dr[i]), 32'(exp_dr));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_sclk[%0d]", tag, i), 32'(sclk[i]), 32'(POL[i]));
      check_eq($sformatf("%s_cs[%0d]", tag, i), 32'(cs[i]), 32'd1);
      check_eq($sformatf("%s_mosi[%0d]", tag, i), 32'(mosi[i]), 32'd1);
      check_eq($sformatf("%s_wbusy[%0d]", tag, i), 32'(wb[i]), 32'd0);
      check_eq($sformatf("%s_rbusy[%0d]", tag, i), 32'(rb[i]), 32'd0);
      check_eq($sformatf("%s_dread[%0d]", tag, i), 32'(dr[i]), 32'(exp_dr));
    end
  endtask

  task automatic reset_mid_frame();
    int guard;
    @(negedge clk);
    slave_byte  = 8'h5B;
    spi_clk_div = 8'd2;
    data_write  = 8'($urandom);
    write_en    = 1'b1;
    read_en     = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    read_en  = 1'b0;
    guard = 0;
    while ((edges[0] < 6) && (guard < 200)) begin
      @(negedge clk);
      guard++;
    end
    check_eq("abort_reached_bit3", 32'(guard < 200), 32'd1);
    #2 rst = 1'b1;
    exp_dr = 8'h00;
    #1 check_idle_outputs("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_abort");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("after_reset");

    run_frame(1'b1, 1'b0, 8'hA5, 8'h00, 8'd4, 1'b0);
    run_frame(1'b0, 1'b1, 8'h00, 8'h3C, 8'd4, 1'b0);
    run_frame(1'b1, 1'b1, 8'h81, 8'h7E, 8'd4, 1'b0);
    check_eq("duplex_busy_equal", 32'(wb_n[0]), 32'(rb_n[0]));
    run_frame(1'b1, 1'b0, 8'h5A, 8'hFF, 8'd0, 1'b1);
    run_frame(1'b1, 1'b0, 8'hC3, 8'h00, 8'd4, 1'b0);
    run_frame(1'b1, 1'b1, 8'h00, 8'hFF, 8'd0, 1'b0);
    run_frame(1'b1, 1'b1, 8'hFF, 8'h00, 8'd1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      int m;
      m = int'($urandom_range(1, 3));
      run_frame(m[0], m[1], 8'($urandom), 8'($urandom),
                8'($urandom_range(0, 6)), ($urandom_range(0, 3) == 0));
    end

    reset_mid_frame();
    run_frame(1'b0, 1'b1, 8'h00, 8'h96, 8'd1, 1'b0);

    check_eq("idle_levels[0]", 32'(idle_bad[0]), 32'd0);
    check_eq("idle_levels[1]", 32'(idle_bad[1]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
